// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter for the write port of the asynchronous FIFO.
// Locks the write port to one requester for a whole packet so packets stay
// contiguous in the FIFO. A one-entry output register drives the FIFO write
// port and holds its beat while the FIFO is full.
//
// Ports:
//   clk, reset           write-domain clock, synchronous active-high reset
//   req/req_data/req_last per-requester beat valid, data (WIDTH per slot), end-of-packet
//   gnt                  per-requester ready; a beat moves on req[i] && gnt[i]
//   fifo_full            FIFO full flag
//   fifo_w_data/_enable  FIFO write port (registered)
//   active_id, busy      current owner and lock status
//   err_overlen          one-cycle pulse when a packet is cut at MAX_PKT beats
module fifo_wr_arbiter #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned MAX_PKT = 16,
  localparam int unsigned IDW    = $clog2(NUM_REQ)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*WIDTH-1:0]   req_data,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         gnt,
  input  logic                       fifo_full,
  output logic [WIDTH-1:0]           fifo_w_data,
  output logic                       fifo_w_enable,
  output logic [IDW-1:0]             active_id,
  output logic                       busy,
  output logic                       err_overlen
);

  localparam int unsigned CW = $clog2(MAX_PKT + 1);

  typedef enum logic {StIdle, StLock} state_e;

  state_e           state_q, state_d;
  logic [IDW-1:0]   owner_q, owner_d;
  logic [IDW-1:0]   last_owner_q, last_owner_d;
  logic [CW-1:0]    beat_cnt_q, beat_cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             err_q, err_d;

  logic [WIDTH-1:0] req_data_arr [NUM_REQ];
  logic             slot_free;
  logic             accept;
  logic             at_max;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign req_data_arr[g] = req_data[g*WIDTH +: WIDTH];
  end

  // First set requester after 'last', wrapping; scanning downward lets the
  // nearest candidate overwrite farther ones.
  function automatic logic [IDW-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                             input logic [IDW-1:0]     last);
    logic [IDW-1:0] p;
    p = last;
    for (int i = NUM_REQ; i >= 1; i--) begin
      if (r[(int'(last) + i) % NUM_REQ]) p = IDW'((int'(last) + i) % NUM_REQ);
    end
    return p;
  endfunction

  // The output slot can take a beat if empty or draining this cycle.
  assign slot_free = !out_valid_q || !fifo_full;
  assign accept    = (state_q == StLock) && slot_free && req[owner_q];
  assign at_max    = (beat_cnt_q == CW'(MAX_PKT - 1));

  always_comb begin
    gnt = '0;
    if (state_q == StLock) gnt[owner_q] = slot_free;
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    beat_cnt_d   = beat_cnt_q;
    out_valid_d  = out_valid_q && fifo_full;
    data_d       = data_q;
    err_d        = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (|req) begin
          owner_d    = rr_pick(req, last_owner_q);
          beat_cnt_d = '0;
          state_d    = StLock;
        end
      end
      StLock: begin
        if (accept) begin
          out_valid_d = 1'b1;
          data_d      = req_data_arr[owner_q];
          beat_cnt_d  = beat_cnt_q + CW'(1);
          if (req_last[owner_q] || at_max) begin
            state_d      = StIdle;
            last_owner_d = owner_q;
            // A genuine last beat landing exactly on MAX_PKT is not an error.
            err_d        = !req_last[owner_q];
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      owner_q      <= '0;
      last_owner_q <= IDW'(NUM_REQ - 1);
      beat_cnt_q   <= '0;
      out_valid_q  <= 1'b0;
      data_q       <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      beat_cnt_q   <= beat_cnt_d;
      out_valid_q  <= out_valid_d;
      data_q       <= data_d;
      err_q        <= err_d;
    end
  end

  assign fifo_w_data   = data_q;
  assign fifo_w_enable = out_valid_q;
  assign active_id     = owner_q;
  assign busy          = (state_q == StLock);
  assign err_overlen   = err_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter. Per-requester beat queues feed a
// driver; expected FIFO writes are queued in hand-computed arbitration order
// and a monitor pops them as the FIFO consumes beats.
module tb_fifo_wr_arbiter;
  localparam int W    = 8;
  localparam int N    = 4;
  localparam int MAXP = 16;
  localparam int IDW  = 2;

  logic           clk;
  logic           reset;
  logic [N-1:0]   req;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   gnt;
  logic           fifo_full;
  logic [W-1:0]   fifo_w_data;
  logic           fifo_w_enable;
  logic [IDW-1:0] active_id;
  logic           busy;
  logic           err_overlen;

  fifo_wr_arbiter #(.WIDTH(W), .NUM_REQ(N), .MAX_PKT(MAXP)) dut (
    .clk           (clk),
    .reset         (reset),
    .req           (req),
    .req_data      (req_data),
    .req_last      (req_last),
    .gnt           (gnt),
    .fifo_full     (fifo_full),
    .fifo_w_data   (fifo_w_data),
    .fifo_w_enable (fifo_w_enable),
    .active_id     (active_id),
    .busy          (busy),
    .err_overlen   (err_overlen)
  );

  typedef struct packed {
    logic [W-1:0] d;
    logic         l;
  } beat_t;

  beat_t        bq [N][$];
  logic [W-1:0] exp_q [$];
  bit           hold [N];
  bit           full_drv;
  int           n_vec;
  int           n_mis;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic send(input int r, input logic [W-1:0] base, input int n, input bit with_last);
    beat_t b;
    for (int k = 0; k < n; k++) begin
      b.d = base + W'(k);
      b.l = with_last && (k == n - 1);
      bq[r].push_back(b);
    end
  endtask

  task automatic expect_beats(input logic [W-1:0] base, input int n);
    for (int k = 0; k < n; k++) exp_q.push_back(base + W'(k));
  endtask

  task automatic wait_busy(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (busy) begin
        ok = 1'b1;
        break;
      end
    end
    check(name, 32'(ok), 32'd1);
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 200; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk); #1;
    end
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    full_drv = 1'b0;
    exp_q.delete();
    for (int i = 0; i < N; i++) begin
      bq[i].delete();
      hold[i] = 1'b0;
    end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // Driver: inputs change on the falling edge; a beat is retired when the
  // settled req && gnt guarantees the coming rising edge takes it.
  initial begin
    req = '0;
    req_last = '0;
    req_data = '0;
    fifo_full = 1'b0;
    forever begin
      @(negedge clk);
      fifo_full = full_drv;
      for (int i = 0; i < N; i++) begin
        if (!hold[i] && bq[i].size() > 0) begin
          req[i] = 1'b1;
          req_last[i] = bq[i][0].l;
          req_data[i*W +: W] = bq[i][0].d;
        end else begin
          req[i] = 1'b0;
          req_last[i] = 1'b0;
        end
      end
      #1;
      if (!reset) begin
        for (int i = 0; i < N; i++) begin
          if (req[i] && gnt[i]) void'(bq[i].pop_front());
        end
      end
    end
  end

  // Monitor: a beat is consumed at the next rising edge when enable && !full.
  initial begin
    forever begin
      @(negedge clk); #2;
      if (!reset && fifo_w_enable && !fifo_full) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_mis++;
          $display("FAIL unexpected_write: got 0x%0h, expected no write at %0t",
                   fifo_w_data, $time);
        end else begin
          check("write_data", 32'(fifo_w_data), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    #300000;
    n_mis++;
    $display("FAIL watchdog: got timeout, expected bench completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $fatal(1);
  end

  initial begin
    int nb;
    int ne;
    n_vec = 0;
    n_mis = 0;
    reset = 1'b1;
    full_drv = 1'b0;
    for (int i = 0; i < N; i++) hold[i] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_en", 32'(fifo_w_enable), 32'd0);
    check("rst_active_id", 32'(active_id), 32'd0);
    check("rst_err", 32'(err_overlen), 32'd0);
    check("rst_data", 32'(fifo_w_data), 32'd0);
    reset = 1'b0;

    // Single 3-beat packet from requester 2.
    expect_beats(8'h20, 3);
    send(2, 8'h20, 3, 1'b1);
    wait_busy("single_busy");
    check("single_active_id", 32'(active_id), 32'd2);
    check("single_en_lat", 32'(fifo_w_enable), 32'd0);
    @(posedge clk); #1;
    check("single_en_b0", 32'(fifo_w_enable), 32'd1);
    check("single_busy_b0", 32'(busy), 32'd1);
    @(posedge clk); #1;
    check("single_en_b1", 32'(fifo_w_enable), 32'd1);
    check("single_busy_b1", 32'(busy), 32'd1);
    @(posedge clk); #1;
    check("single_en_b2", 32'(fifo_w_enable), 32'd1);
    check("single_busy_released", 32'(busy), 32'd0);
    @(posedge clk); #1;
    check("single_en_done", 32'(fifo_w_enable), 32'd0);
    wait_drain("single_drain");

    // Round-robin: every requester has two 2-beat packets queued.
    do_reset();
    for (int p = 0; p < 2; p++) begin
      for (int r = 0; r < N; r++) expect_beats(8'(r * 16 + p * 2), 2);
    end
    for (int r = 0; r < N; r++) begin
      for (int p = 0; p < 2; p++) send(r, 8'(r * 16 + p * 2), 2, 1'b1);
    end
    wait_busy("rr_busy");
    check("rr_first_owner", 32'(active_id), 32'd0);
    // 8 packets x 2 busy cycles with a single idle bubble between each.
    nb = 1;
    repeat (22) begin
      @(posedge clk); #1;
      if (busy) nb++;
    end
    check("rr_busy_cycles", 32'(nb), 32'd16);
    @(posedge clk); #1;
    check("rr_final_idle", 32'(busy), 32'd0);
    wait_drain("rr_drain");

    // Backpressure: full for 5 cycles while beat 0x11 sits in the output reg.
    do_reset();
    expect_beats(8'h10, 6);
    send(1, 8'h10, 6, 1'b1);
    wait_busy("bp_busy");
    @(posedge clk); #1;
    @(posedge clk); #1;
    full_drv = 1'b1;
    repeat (5) begin
      @(negedge clk); #3;
      check("bp_gnt", 32'(gnt), 32'd0);
      check("bp_hold_data", 32'(fifo_w_data), 32'h11);
      check("bp_en", 32'(fifo_w_enable), 32'd1);
    end
    full_drv = 1'b0;
    @(negedge clk); #3;
    check("bp_gnt_recover", 32'(gnt), 32'b0010);
    wait_drain("bp_drain");

    // Overlength: 20 beats without last from 1, requester 2 waiting.
    do_reset();
    send(1, 8'h80, 20, 1'b0);
    send(2, 8'hA0, 2, 1'b1);
    expect_beats(8'h80, 16);
    expect_beats(8'hA0, 2);
    expect_beats(8'h90, 4);
    ne = 0;
    repeat (60) begin
      @(posedge clk); #1;
      if (err_overlen) ne++;
    end
    check("ovl_err_pulses", 32'(ne), 32'd1);
    check("ovl_relock_owner", 32'(active_id), 32'd1);
    wait_drain("ovl_drain");

    // Owner stall: requester 0 drops req for 4 cycles, 3 waits.
    do_reset();
    send(0, 8'h00, 4, 1'b1);
    send(3, 8'h30, 2, 1'b1);
    expect_beats(8'h00, 4);
    expect_beats(8'h30, 2);
    wait_busy("stall_busy");
    check("stall_owner", 32'(active_id), 32'd0);
    @(posedge clk); #1;
    hold[0] = 1'b1;
    repeat (4) begin
      @(negedge clk); #3;
      check("stall_gnt", 32'(gnt), 32'b0001);
      check("stall_busy_held", 32'(busy), 32'd1);
      check("stall_owner_held", 32'(active_id), 32'd0);
    end
    hold[0] = 1'b0;
    wait_drain("stall_drain");

    // Reset while a beat is stalled under full; the held beat is discarded.
    do_reset();
    send(0, 8'hC0, 4, 1'b1);
    send(1, 8'hD0, 1, 1'b1);
    wait_busy("rstm_busy");
    @(posedge clk); #1;
    full_drv = 1'b1;
    @(posedge clk); #1;
    bq[0].delete();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("rstm_en", 32'(fifo_w_enable), 32'd0);
    check("rstm_busy_clr", 32'(busy), 32'd0);
    check("rstm_data_clr", 32'(fifo_w_data), 32'd0);
    full_drv = 1'b0;
    send(0, 8'hE0, 1, 1'b1);
    expect_beats(8'hE0, 1);
    expect_beats(8'hD0, 1);
    wait_busy("rstm_rebusy");
    check("rstm_first_owner", 32'(active_id), 32'd0);
    wait_drain("rstm_drain");

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-port arbiter that shares the write side of the asynchronous FIFO between `NUM_REQ` packet sources in the write clock domain. It locks the FIFO write port to one requester for a whole packet, which keeps packets contiguous in the FIFO. A one-entry output register drives `fifo_w_data`/`fifo_w_enable` and honours the FIFO `full` flag. It sits directly in front of the FIFO write port; `clk` is the FIFO write clock.

## Interface
- `WIDTH`, 8, data width; equals FIFO `WIDTH`.
- `NUM_REQ`, 4, number of requesters, ≥2; `IDW = $clog2(NUM_REQ)`.
- `MAX_PKT`, 16, maximum beats per packet before forced release, ≥2.

- `clk` in 1: single clock (FIFO write clock).
- `reset` in 1: synchronous, active-high reset.
- `req` in NUM_REQ: per-requester beat valid.
- `req_data` in NUM_REQ*WIDTH: requester i data in bits [i*WIDTH +: WIDTH].
- `req_last` in NUM_REQ: the beat is the last of its packet.
- `gnt` out NUM_REQ: per-requester ready. A beat transfers when `req[i] && gnt[i]`.
- `fifo_full` in 1: FIFO full flag.
- `fifo_w_data` out WIDTH: FIFO write data.
- `fifo_w_enable` out 1: FIFO write enable.
- `active_id` out IDW: current owner, valid while `busy`.
- `busy` out 1: a packet is locked.
- `err_overlen` out 1: one-cycle pulse on forced release.

## Operation
- **States:** IDLE and LOCK.
- **IDLE:**
  - `gnt` = 0.
  - If any `req` is set, select the first set requester searching from `last_owner+1` upward, wrapping mod NUM_REQ.
  - Register `owner`, clear `beat_cnt`, go to LOCK.
  - If no `req` is set, stay in IDLE.
- **LOCK:**
  - `gnt[owner] = slot_free`; every other `gnt` bit is 0.
  - `slot_free = !out_valid || !fifo_full`.
  - On an accepted beat: load the output register with the owner's data, set `out_valid`, and increment `beat_cnt`.
  - Release when the accepted beat has `req_last`, or when it is beat number `MAX_PKT`. The second case pulses `err_overlen` on the next cycle.
  - On release: `last_owner <= owner`, go to IDLE.
  - If the owner deasserts `req` mid-packet, hold the lock indefinitely. No timeout.
- **Output register:**
  - `fifo_w_enable = out_valid`.
  - When `out_valid && !fifo_full`, the FIFO consumes the beat. `out_valid` clears unless a new beat is loaded in the same cycle.
  - A beat held while `fifo_full` keeps its data stable until it drains. Beats are never dropped or duplicated.
- **Round-robin:**
  - `last_owner` resets to NUM_REQ-1, so requester 0 has first priority after reset.
  - A requester that just released has lowest priority in the next arbitration.
- **`beat_cnt`:** width `$clog2(MAX_PKT+1)`; it cannot overflow because release occurs at `MAX_PKT`.
- **`active_id` / `busy`:** `active_id = owner`; `busy = (state == LOCK)`.
- **Reset (synchronous, highest priority):**
  - Signals: state IDLE, `owner` 0, `last_owner` NUM_REQ-1, `beat_cnt` 0, `out_valid` 0, `fifo_w_data` 0, `err_overlen` 0.
  - Resulting outputs: `gnt` 0, `busy` 0, `active_id` 0.
  - Reset mid-packet discards the held beat and the lock. `fifo_w_enable` is 0 the cycle after reset is sampled.

## Timing
- `gnt` is combinational from registered state and `fifo_full`. All other outputs are registered.
- Arbitration latency:
  - `req` sampled in IDLE at edge t.
  - LOCK at t+1, with `gnt` high at t+1 if the slot is free.
  - The first beat is accepted at edge t+1 and appears on `fifo_w_enable` in the cycle t+1..t+2.
- Streaming: with `fifo_full` low, one beat per cycle; the output register sustains full throughput.
- One IDLE bubble cycle between consecutive packets, including back-to-back packets from the same requester.
- Release and IDLE transition happen on the edge that accepts the last beat. The next owner's `gnt` is high one cycle after IDLE.
- Backpressure: when `fifo_full` rises while `out_valid`, `gnt` falls in the same cycle. It recovers in the cycle `fifo_full` falls.

## Test plan
- **Single packet:** reset; `req[2]` sends a 3-beat packet D0,D1,D2 with `req_last` on D2 → `fifo_w_enable` high 3 consecutive cycles with D0,D1,D2; `active_id` = 2 during the packet; `busy` falls after D2 is accepted.
- **Round-robin:** all 4 requesters each send 2-beat packets continuously → owner order 0,1,2,3,0,…; exactly one IDLE cycle between packets; no interleaving within a packet.
- **Backpressure:**
  - Stimulus: hold `fifo_full` = 1 for 5 cycles mid-packet.
  - Response: `gnt` = 0 while the held beat stays on `fifo_w_data` unchanged; `fifo_w_enable` stays 1.
  - Check: after release, every beat written exactly once, in order.
- **Overlength:** with `MAX_PKT` = 16, requester 1 sends 20 beats with no `req_last` → release after beat 16; `err_overlen` pulses once; requester 2, if pending, is granted next.
- **Owner stall:** owner drops `req` for 4 cycles mid-packet while others request → lock held; no other `gnt`; the packet completes when `req` returns.
- **Reset mid-packet:** assert `reset` for 1 cycle during a beat stall under `fifo_full` → next cycle `fifo_w_enable` = 0 and `busy` = 0; requester 0 is granted first afterwards.
